// File: rtl/psum_drain_pkg.sv
// Shared definitions for the psum drain controller: FSM encoding and a
// ceiling-log2 helper used to size FIFO pointers and small counters.
package psum_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/psum_drain_fifo.sv
// Small synchronous FIFO holding drained words plus their last flag.
// The occupancy count feeds the read-credit check in the controller.
// Push and pop in the same cycle are allowed even when full.
module psum_drain_fifo
  import psum_drain_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic [clog2(DEPTH):0]    o_count
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;

  logic w_full;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && (!w_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rptr];
  assign o_count   = r_count;

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset because the empty flag masks them.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/psum_drain_ctrl.sv
// Drains accumulated psum words from the buffer in address order onto a
// valid/ready stream, optionally zeroing each address as its data returns.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start (ignored while the post-reset guard runs)
//   ST_ISSUE | issuing reads whenever in-flight + buffered words fit the FIFO
//   ST_WAIT  | all reads issued, waiting for the consumer to take the rest
//   ST_DONE  | one-cycle completion pulse
//
// Read credit counts words still in the memory pipe plus words parked in
// the FIFO, so every returning word always has a slot and none is dropped.
module psum_drain_ctrl
  import psum_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DELAY  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_addr,
  input  logic                  clear_en,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  input  logic                  mem_oval,
  output logic [ADDR_WIDTH-1:0] mem_wadd,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_idat,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_last
);

  localparam int PW = clog2(FIFO_DEPTH);
  localparam int GW = clog2(MEM_DELAY + 2);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_num_addr;
  logic                  r_clear_en;
  logic [ADDR_WIDTH-1:0] r_issue_cnt;
  logic [ADDR_WIDTH-1:0] r_ret_cnt;
  logic [ADDR_WIDTH-1:0] r_pop_cnt;
  logic [GW-1:0]         r_guard;

  logic                  w_start_acc;
  logic [ADDR_WIDTH-1:0] w_outstanding;
  logic [ADDR_WIDTH-1:0] w_credit_used;
  logic                  w_rden;
  logic                  w_oval_acc;
  logic                  w_is_last;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_pop_cnt_nxt;
  logic [DATA_WIDTH:0]   w_fifo_din;
  logic [DATA_WIDTH:0]   w_fifo_dout;
  logic                  w_fifo_empty;
  logic [PW:0]           w_fifo_count;

  assign w_start_acc   = (r_state == ST_IDLE) && (r_guard == '0) && start;
  assign w_outstanding = r_issue_cnt - r_ret_cnt;
  assign w_credit_used = w_outstanding + ADDR_WIDTH'(w_fifo_count);
  assign w_rden        = (r_state == ST_ISSUE) && (w_credit_used < ADDR_WIDTH'(FIFO_DEPTH));
  // Data is only taken while a read is in flight; stale returns after reset fall through.
  assign w_oval_acc    = mem_oval && (w_outstanding != '0);
  assign w_is_last     = (r_ret_cnt == (r_num_addr - ADDR_WIDTH'(1)));
  assign w_fifo_din    = {w_is_last, mem_odat};
  assign w_pop         = out_vld && out_rdy;
  assign w_pop_cnt_nxt = r_pop_cnt + ADDR_WIDTH'(w_pop);

  psum_drain_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_oval_acc),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; WAIT looks at the pop happening this cycle so done follows the last transfer directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) w_state_nxt = (num_addr == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_rden && ((r_issue_cnt + ADDR_WIDTH'(1)) == r_num_addr)) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_pop_cnt_nxt == r_num_addr) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Drain counters and latched job parameters; everything restarts on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_addr  <= '0;
      r_clear_en  <= 1'b0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_pop_cnt   <= '0;
    end else if (w_start_acc) begin
      r_num_addr  <= num_addr;
      r_clear_en  <= clear_en;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_pop_cnt   <= '0;
    end else begin
      if (w_rden)     r_issue_cnt <= r_issue_cnt + ADDR_WIDTH'(1);
      if (w_oval_acc) r_ret_cnt   <= r_ret_cnt + ADDR_WIDTH'(1);
      if (w_pop)      r_pop_cnt   <= r_pop_cnt + ADDR_WIDTH'(1);
    end
  end

  // Post-reset guard: hold off start until reads issued before reset have drained from the memory pipe.
  always_ff @(posedge clk) begin
    if (rst)                 r_guard <= GW'(MEM_DELAY);
    else if (r_guard != '0)  r_guard <= r_guard - GW'(1);
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign mem_rden = w_rden;
  assign mem_radd = w_rden ? r_issue_cnt : '0;
  assign mem_wren = w_oval_acc && r_clear_en;
  assign mem_wadd = mem_wren ? r_ret_cnt : '0;
  assign mem_idat = '0;
  assign out_vld  = !w_fifo_empty;
  assign out_dat  = out_vld ? w_fifo_dout[DATA_WIDTH-1:0] : '0;
  assign out_last = out_vld && w_fifo_dout[DATA_WIDTH];

endmodule
